// File: rtl/battleship_display_arbiter.sv
// Shares the 4-digit seven-segment display between alert, score and ships
// images. Optional alert blink is enabled by BATTLESHIP_DISPLAY_BLINK_EN.
module battleship_display_arbiter #(
   parameter int unsigned HOLD_CYCLES  = 50_000_000,
   parameter int unsigned BLINK_CYCLES = 12_500_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  req,
   input  logic [27:0] seg_alert,
   input  logic [27:0] seg_score,
   input  logic [27:0] seg_ships,
   output logic [2:0]  gnt,
   output logic [27:0] ships_out,
   output logic        busy
);

   localparam int unsigned CW =
      (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_OWN  = 1'b1;

   if (HOLD_CYCLES < 1 || BLINK_CYCLES < 1) begin : g_bad_param
      $error("HOLD_CYCLES and BLINK_CYCLES must be >= 1");
   end

   logic [0:0]    state, state_d;
   logic [2:0]    gnt_d;
   logic [CW-1:0] cnt, cnt_d;
   logic [2:0]    others;
   logic [27:0]   img_alert;
   logic [27:0]   img;

   function automatic logic [2:0] pick(input logic [2:0] r);
      if (r[0])      return 3'b001;
      else if (r[1]) return 3'b010;
      else if (r[2]) return 3'b100;
      else           return 3'b000;
   endfunction

   assign others = req & ~gnt;
   assign busy   = (state == S_OWN) && (cnt != '0);

   // Next owner: alert preempts, dwell holds the owner, then re-arbitrate.
   always_comb begin
      state_d = state;
      gnt_d   = gnt;
      cnt_d   = cnt;
      if (state == S_IDLE) begin
         if (req != 3'b000) begin
            state_d = S_OWN;
            gnt_d   = pick(req);
            cnt_d   = RELOAD;
         end
      end else if (req[0] && !gnt[0]) begin
         gnt_d = 3'b001;
         cnt_d = RELOAD;
      end else if (cnt != '0) begin
         cnt_d = cnt - 1'b1;
      end else if (gnt[0] && req[0]) begin
         cnt_d = RELOAD;
      end else if (others != 3'b000) begin
         gnt_d = pick(others);
         cnt_d = RELOAD;
      end else if ((req & gnt) != 3'b000) begin
         cnt_d = RELOAD;
      end else begin
         state_d = S_IDLE;
         gnt_d   = 3'b000;
         cnt_d   = '0;
      end
   end

`ifdef BATTLESHIP_DISPLAY_BLINK_EN
   localparam int unsigned BW =
      (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [BW-1:0] BLAST = BW'(BLINK_CYCLES - 1);

   logic [BW-1:0] bcnt;
   logic          vis;

   // Blink phase restarts visible on every new alert grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcnt <= '0;
         vis  <= 1'b1;
      end else if (gnt_d[0] && !gnt[0]) begin
         bcnt <= '0;
         vis  <= 1'b1;
      end else if (gnt[0]) begin
         if (bcnt == BLAST) begin
            bcnt <= '0;
            vis  <= ~vis;
         end else begin
            bcnt <= bcnt + 1'b1;
         end
      end
   end

   assign img_alert = vis ? seg_alert : 28'h0;
`else
   assign img_alert = seg_alert;
`endif

   // Image of the current owner; never a mix of sources.
   always_comb begin
      img = 28'h0;
      unique case (1'b1)
         gnt[0]:  img = img_alert;
         gnt[1]:  img = seg_score;
         gnt[2]:  img = seg_ships;
         default: img = 28'h0;
      endcase
   end

   // Arbiter state and registered display word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         gnt       <= 3'b000;
         cnt       <= '0;
         ships_out <= 28'h0;
      end else begin
         state     <= state_d;
         gnt       <= gnt_d;
         cnt       <= cnt_d;
         ships_out <= img;
      end
   end

endmodule

// File: tb/tb_battleship_display_arbiter.sv
// Scoreboard bench for battleship_display_arbiter, HOLD_CYCLES=4,
// BLINK_CYCLES=2; expected outputs per clock edge are hand computed.
module tb_battleship_display_arbiter;

   logic        clk;
   logic        rst_n;
   logic [2:0]  req;
   logic [27:0] seg_alert;
   logic [27:0] seg_score;
   logic [27:0] seg_ships;
   logic [2:0]  gnt;
   logic [27:0] ships_out;
   logic        busy;

`ifdef BATTLESHIP_DISPLAY_BLINK_EN
   localparam bit BLK = 1'b1;
`else
   localparam bit BLK = 1'b0;
`endif

   localparam logic [27:0] AL = 28'h1234567;
   localparam logic [27:0] SC = 28'h7654321;
   localparam logic [27:0] SH = 28'h0ABCDEF;
   localparam logic [27:0] AB = BLK ? 28'h0 : AL;

   typedef struct {
      int          tag;
      logic [2:0]  g;
      logic [27:0] o;
      logic        b;
   } exp_t;

   exp_t q[$];
   int   n_run;
   int   n_fail;

   battleship_display_arbiter #(
      .HOLD_CYCLES (4),
      .BLINK_CYCLES(2)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .seg_alert(seg_alert),
      .seg_score(seg_score),
      .seg_ships(seg_ships),
      .gnt      (gnt),
      .ships_out(ships_out),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input int tag, input logic [2:0] g,
                      input logic [27:0] o, input logic b);
      n_run++;
      if (gnt !== g || ships_out !== o || busy !== b) begin
         n_fail++;
         $display("FAIL t%0d: gnt=%b out=%h busy=%b, want gnt=%b out=%h busy=%b",
                  tag, gnt, ships_out, busy, g, o, b);
      end
   endtask

   // Monitor: every output cycle, compare against the oldest expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.tag, e.g, e.o, e.b);
         end
      end
   end

   // Apply req, clock one edge, queue the response expected after it.
   task automatic cyc(input int tag, input logic [2:0] r,
                      input logic [2:0] g, input logic [27:0] o,
                      input logic b);
      exp_t e;
      req = r;
      @(posedge clk);
      #1;
      e.tag = tag;
      e.g   = g;
      e.o   = o;
      e.b   = b;
      q.push_back(e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      n_run     = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      req       = 3'b000;
      seg_alert = AL;
      seg_score = SC;
      seg_ships = SH;
      #12;
      chk(0, 3'b000, 28'h0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Ships alone: grant, image one edge later, dwell, back to idle.
      cyc(101, 3'b100, 3'b100, 28'h0, 1'b1);
      cyc(102, 3'b100, 3'b100, SH, 1'b1);
      cyc(103, 3'b100, 3'b100, SH, 1'b1);
      cyc(104, 3'b100, 3'b100, SH, 1'b0);
      cyc(105, 3'b000, 3'b000, SH, 1'b0);
      cyc(106, 3'b000, 3'b000, 28'h0, 1'b0);

      // Score and ships rotate every 4 cycles with no gap.
      cyc(201, 3'b110, 3'b010, 28'h0, 1'b1);
      cyc(202, 3'b110, 3'b010, SC, 1'b1);
      cyc(203, 3'b110, 3'b010, SC, 1'b1);
      cyc(204, 3'b110, 3'b010, SC, 1'b0);
      cyc(205, 3'b110, 3'b100, SC, 1'b1);
      cyc(206, 3'b110, 3'b100, SH, 1'b1);
      cyc(207, 3'b110, 3'b100, SH, 1'b1);
      cyc(208, 3'b110, 3'b100, SH, 1'b0);
      cyc(209, 3'b110, 3'b010, SH, 1'b1);
      cyc(210, 3'b110, 3'b010, SC, 1'b1);
      cyc(211, 3'b000, 3'b010, SC, 1'b1);
      cyc(212, 3'b000, 3'b010, SC, 1'b0);
      cyc(213, 3'b000, 3'b000, SC, 1'b0);
      cyc(214, 3'b000, 3'b000, 28'h0, 1'b0);

      // Alert preempts ships mid-dwell.
      cyc(301, 3'b100, 3'b100, 28'h0, 1'b1);
      cyc(302, 3'b100, 3'b100, SH, 1'b1);
      cyc(303, 3'b101, 3'b001, SH, 1'b1);
      cyc(304, 3'b101, 3'b001, AL, 1'b1);
      cyc(305, 3'b000, 3'b001, AL, 1'b1);
      cyc(306, 3'b000, 3'b001, AB, 1'b0);
      cyc(307, 3'b000, 3'b000, AB, 1'b0);
      cyc(308, 3'b000, 3'b000, 28'h0, 1'b0);

      // Score keeps its full dwell after its request drops.
      cyc(401, 3'b010, 3'b010, 28'h0, 1'b1);
      cyc(402, 3'b000, 3'b010, SC, 1'b1);
      cyc(403, 3'b000, 3'b010, SC, 1'b1);
      cyc(404, 3'b000, 3'b010, SC, 1'b0);
      cyc(405, 3'b000, 3'b000, SC, 1'b0);
      cyc(406, 3'b000, 3'b000, 28'h0, 1'b0);

      // Asynchronous reset mid-dwell, then restart from idle.
      cyc(501, 3'b010, 3'b010, 28'h0, 1'b1);
      cyc(502, 3'b010, 3'b010, SC, 1'b1);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk(503, 3'b000, 28'h0, 1'b0);
      @(posedge clk);
      #2;
      chk(504, 3'b000, 28'h0, 1'b0);
      rst_n = 1'b1;
      cyc(505, 3'b010, 3'b010, 28'h0, 1'b1);
      cyc(506, 3'b000, 3'b010, SC, 1'b1);
      cyc(507, 3'b000, 3'b010, SC, 1'b1);
      cyc(508, 3'b000, 3'b010, SC, 1'b0);
      cyc(509, 3'b000, 3'b000, SC, 1'b0);
      cyc(510, 3'b000, 3'b000, 28'h0, 1'b0);

      // Alert beats score when both arrive; alert held keeps the display.
      cyc(601, 3'b011, 3'b001, 28'h0, 1'b1);
      cyc(602, 3'b011, 3'b001, AL, 1'b1);
      cyc(603, 3'b011, 3'b001, AL, 1'b1);
      cyc(604, 3'b011, 3'b001, AB, 1'b0);
      cyc(605, 3'b011, 3'b001, AB, 1'b1);
      cyc(606, 3'b011, 3'b001, AL, 1'b1);
      cyc(607, 3'b011, 3'b001, AL, 1'b1);
      cyc(608, 3'b000, 3'b001, AB, 1'b0);
      cyc(609, 3'b000, 3'b000, AB, 1'b0);
      cyc(610, 3'b000, 3'b000, 28'h0, 1'b0);

      @(negedge clk);
      #1;
      n_run++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
